// File: rtl/cache_arb_pkg.sv
// Shared types for the I/D cache to L2 arbiter: FSM states, captured
// operation codes, grant tracking and default bus widths.
package cache_arb_pkg;

    localparam int DEF_ADDR_WIDTH = 16;
    localparam int DEF_LINE_WIDTH = 128;

    typedef logic [DEF_ADDR_WIDTH-1:0] addr_t;
    typedef logic [DEF_LINE_WIDTH-1:0] line_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        DONE    = 2'd3
    } arb_state_t;

    typedef enum logic [1:0] {
        NONE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } arb_op_t;

    // Which requester won the most recent tie; the other one wins the next.
    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_t;

endpackage

// File: rtl/cache_arbiter_if.sv
// Bus bundle between the two L1 caches, the arbiter and the shared L2.
// The slave modport is the arbiter's view; master is the surrounding system.
interface cache_arbiter_if
    import cache_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int LINE_WIDTH = DEF_LINE_WIDTH
);

    logic                  i_read;
    logic [ADDR_WIDTH-1:0] i_address;
    logic [LINE_WIDTH-1:0] i_rdata;
    logic                  i_resp;

    logic                  d_read;
    logic                  d_write;
    logic [ADDR_WIDTH-1:0] d_address;
    logic [LINE_WIDTH-1:0] d_wdata;
    logic [LINE_WIDTH-1:0] d_rdata;
    logic                  d_resp;

    logic                  l2_read;
    logic                  l2_write;
    logic [ADDR_WIDTH-1:0] l2_address;
    logic [LINE_WIDTH-1:0] l2_wdata;
    logic [LINE_WIDTH-1:0] l2_rdata;
    logic                  l2_resp;

    modport slave (
        input  i_read, i_address, d_read, d_write, d_address, d_wdata,
               l2_rdata, l2_resp,
        output i_rdata, i_resp, d_rdata, d_resp,
               l2_read, l2_write, l2_address, l2_wdata
    );

    modport master (
        output i_read, i_address, d_read, d_write, d_address, d_wdata,
               l2_rdata, l2_resp,
        input  i_rdata, i_resp, d_rdata, d_resp,
               l2_read, l2_write, l2_address, l2_wdata
    );

endinterface

// File: rtl/cache_arb_req_reg.sv
// Holds the operation, address and write data of the request currently
// being forwarded to L2. Write data has its own enable so an I-side grant
// leaves the last D-side write data untouched.
module cache_arb_req_reg
    import cache_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int LINE_WIDTH = DEF_LINE_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic                  load_wdata,
    input  arb_op_t               op_in,
    input  logic [ADDR_WIDTH-1:0] addr_in,
    input  logic [LINE_WIDTH-1:0] wdata_in,
    output arb_op_t               op_q,
    output logic [ADDR_WIDTH-1:0] addr_q,
    output logic [LINE_WIDTH-1:0] wdata_q
);

    // Capture the granted request; cleared immediately on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q    <= NONE;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            if (load) begin
                op_q   <= op_in;
                addr_q <= addr_in;
            end
            if (load_wdata) begin
                wdata_q <= wdata_in;
            end
        end
    end

endmodule

// File: rtl/cache_arbiter.sv
// Round-robin arbiter sharing one L2 port between an I-cache (fills only)
// and a D-cache (fills and writebacks). One transaction at a time, with a
// one-cycle DONE gap between transactions.
module cache_arbiter
    import cache_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int LINE_WIDTH = DEF_LINE_WIDTH
) (
    input logic            clk,
    input logic            reset,
    cache_arbiter_if.slave bus
);

    arb_state_t            state;
    arb_state_t            state_next;
    grant_t                last_grant;
    grant_t                grant_next;

    logic                  load;
    logic                  load_wdata;
    arb_op_t               op_in;
    logic [ADDR_WIDTH-1:0] addr_in;
    logic [LINE_WIDTH-1:0] wdata_in;
    arb_op_t               cap_op;
    logic [ADDR_WIDTH-1:0] cap_addr;
    logic [LINE_WIDTH-1:0] cap_wdata;

    logic                  i_req;
    logic                  d_req;
    logic                  serving;

    assign i_req   = bus.i_read;
    assign d_req   = bus.d_read | bus.d_write;
    assign serving = (state == SERVE_I) || (state == SERVE_D);

    cache_arb_req_reg #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .LINE_WIDTH (LINE_WIDTH)
    ) u_req_reg (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .load_wdata (load_wdata),
        .op_in      (op_in),
        .addr_in    (addr_in),
        .wdata_in   (wdata_in),
        .op_q       (cap_op),
        .addr_q     (cap_addr),
        .wdata_q    (cap_wdata)
    );

    // State and round-robin pointer; reset gives the I-cache the first tie.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= GRANT_D;
        end else begin
            state      <= state_next;
            last_grant <= grant_next;
        end
    end

    // Grant decision, request capture and completion tracking.
    always_comb begin
        state_next = state;
        grant_next = last_grant;
        load       = 1'b0;
        load_wdata = 1'b0;
        op_in      = NONE;
        addr_in    = '0;
        wdata_in   = '0;
        case (state)
            IDLE: begin
                if (i_req && (!d_req || last_grant == GRANT_D)) begin
                    state_next = SERVE_I;
                    load       = 1'b1;
                    op_in      = READ;
                    addr_in    = bus.i_address;
                    if (d_req) begin
                        grant_next = GRANT_I;
                    end
                end else if (d_req) begin
                    state_next = SERVE_D;
                    load       = 1'b1;
                    load_wdata = 1'b1;
                    op_in      = bus.d_write ? WRITE : READ;
                    addr_in    = bus.d_address;
                    wdata_in   = bus.d_wdata;
                    if (i_req) begin
                        grant_next = GRANT_D;
                    end
                end
            end
            SERVE_I, SERVE_D: begin
                if (bus.l2_resp) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.l2_read    = serving && (cap_op == READ);
    assign bus.l2_write   = serving && (cap_op == WRITE);
    assign bus.l2_address = cap_addr;
    assign bus.l2_wdata   = cap_wdata;

    assign bus.i_resp  = (state == SERVE_I) && bus.l2_resp;
    assign bus.d_resp  = (state == SERVE_D) && bus.l2_resp;
    assign bus.i_rdata = bus.l2_rdata;
    assign bus.d_rdata = bus.l2_rdata;

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter: single fills, round-robin ties,
// writeback stability, read+write collapse, reset abort and spurious resp.
module tb_cache_arbiter;
    import cache_arb_pkg::*;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    cache_arbiter_if #(.ADDR_WIDTH(16), .LINE_WIDTH(128)) bus ();

    cache_arbiter #(.ADDR_WIDTH(16), .LINE_WIDTH(128)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_bit(input string tag, input logic observed, input logic expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0b expected=%0b", tag, observed, expected);
        end
    endtask

    task automatic check_addr(input string tag, input addr_t observed, input addr_t expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic check_line(input string tag, input line_t observed, input line_t expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic check_state(input string tag, input arb_state_t observed, input arb_state_t expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Drive a single-cycle L2 completion with the given data, checked mid-cycle.
    task automatic l2_pulse(input line_t data);
        bus.l2_rdata = data;
        bus.l2_resp  = 1'b1;
        #1;
    endtask

    localparam line_t PAT_A5 = {16{8'hA5}};
    localparam line_t PAT_B  = 128'h0B0B_0B0B_1111_2222_3333_4444_5555_6666;
    localparam line_t W1     = 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321;
    localparam line_t W2     = 128'hCAFE_F00D_DEAD_BEEF_0123_4567_89AB_CDEF;

    // Linear sequence of directed steps.
    initial begin
        checks        = 0;
        errors        = 0;
        reset         = 1'b1;
        bus.i_read    = 1'b0;
        bus.i_address = '0;
        bus.d_read    = 1'b0;
        bus.d_write   = 1'b0;
        bus.d_address = '0;
        bus.d_wdata   = '0;
        bus.l2_rdata  = '0;
        bus.l2_resp   = 1'b0;
        #1;
        $display("[TB] reset state");
        check_bit  ("rst_l2_read",  bus.l2_read,  1'b0);
        check_bit  ("rst_l2_write", bus.l2_write, 1'b0);
        check_addr ("rst_l2_addr",  bus.l2_address, 16'h0000);
        check_line ("rst_l2_wdata", bus.l2_wdata, '0);
        check_bit  ("rst_i_resp",   bus.i_resp,   1'b0);
        check_bit  ("rst_d_resp",   bus.d_resp,   1'b0);
        check_state("rst_state",    dut.state,    IDLE);
        @(negedge clk);
        reset = 1'b0;
        step();

        $display("[TB] single I-cache fill");
        bus.i_read    = 1'b1;
        bus.i_address = 16'h3000;
        #1;
        check_bit("a_latency_c0", bus.l2_read, 1'b0);
        step();
        check_bit ("a_l2_read_c1", bus.l2_read,    1'b1);
        check_bit ("a_l2_write",   bus.l2_write,   1'b0);
        check_addr("a_l2_addr",    bus.l2_address, 16'h3000);
        step();
        step();
        step();
        check_bit("a_l2_read_c4", bus.l2_read, 1'b1);
        check_bit("a_i_resp_wait", bus.i_resp, 1'b0);
        l2_pulse(PAT_A5);
        check_bit ("a_i_resp",  bus.i_resp,  1'b1);
        check_bit ("a_d_resp",  bus.d_resp,  1'b0);
        check_line("a_i_rdata", bus.i_rdata, PAT_A5);
        check_line("a_d_rdata", bus.d_rdata, PAT_A5);
        step();
        bus.l2_resp = 1'b0;
        bus.i_read  = 1'b0;
        #1;
        check_state("a_done",       dut.state,   DONE);
        check_bit  ("a_l2_read_off", bus.l2_read, 1'b0);
        check_bit  ("a_i_resp_once", bus.i_resp,  1'b0);
        step();
        check_state("a_idle", dut.state, IDLE);

        $display("[TB] round-robin ties");
        bus.i_read    = 1'b1;
        bus.i_address = 16'h1100;
        bus.d_read    = 1'b1;
        bus.d_address = 16'h2200;
        step();
        check_state("b_tie1_state", dut.state,      SERVE_I);
        check_addr ("b_tie1_addr",  bus.l2_address, 16'h1100);
        l2_pulse(PAT_B);
        check_bit("b_tie1_i_resp", bus.i_resp, 1'b1);
        check_bit("b_tie1_d_resp", bus.d_resp, 1'b0);
        step();
        bus.l2_resp = 1'b0;
        bus.i_read  = 1'b0;
        check_state("b_done1", dut.state, DONE);
        step();
        check_state("b_idle_after_done", dut.state,   IDLE);
        check_bit  ("b_no_grant_done",   bus.l2_read, 1'b0);
        step();
        check_state("b_d_state", dut.state,      SERVE_D);
        check_bit  ("b_d_read",  bus.l2_read,    1'b1);
        check_addr ("b_d_addr",  bus.l2_address, 16'h2200);
        l2_pulse(PAT_B);
        check_bit("b_d_resp",  bus.d_resp, 1'b1);
        check_bit("b_d_iresp", bus.i_resp, 1'b0);
        step();
        bus.l2_resp = 1'b0;
        bus.d_read  = 1'b0;
        step();
        bus.i_read    = 1'b1;
        bus.i_address = 16'h1180;
        bus.d_read    = 1'b1;
        bus.d_address = 16'h2280;
        step();
        check_state("b_tie2_state", dut.state,      SERVE_D);
        check_addr ("b_tie2_addr",  bus.l2_address, 16'h2280);
        l2_pulse(PAT_A5);
        check_bit("b_tie2_d_resp", bus.d_resp, 1'b1);
        check_bit("b_tie2_i_resp", bus.i_resp, 1'b0);
        step();
        bus.l2_resp = 1'b0;
        bus.i_read  = 1'b0;
        bus.d_read  = 1'b0;
        step();

        $display("[TB] writeback held stable after request drops");
        bus.d_write   = 1'b1;
        bus.d_address = 16'h4020;
        bus.d_wdata   = W1;
        step();
        check_bit ("c_l2_write", bus.l2_write,   1'b1);
        check_bit ("c_l2_read",  bus.l2_read,    1'b0);
        check_addr("c_addr",     bus.l2_address, 16'h4020);
        check_line("c_wdata",    bus.l2_wdata,   W1);
        bus.d_write   = 1'b0;
        bus.d_address = 16'hFFFF;
        bus.d_wdata   = '0;
        step();
        step();
        check_bit ("c_hold_write", bus.l2_write,   1'b1);
        check_addr("c_hold_addr",  bus.l2_address, 16'h4020);
        check_line("c_hold_wdata", bus.l2_wdata,   W1);
        l2_pulse(PAT_B);
        check_bit("c_d_resp", bus.d_resp, 1'b1);
        step();
        bus.l2_resp = 1'b0;
        #1;
        check_bit("c_d_resp_once", bus.d_resp,   1'b0);
        check_bit("c_write_off",   bus.l2_write, 1'b0);
        step();

        $display("[TB] read and write together");
        bus.d_read    = 1'b1;
        bus.d_write   = 1'b1;
        bus.d_address = 16'h5040;
        bus.d_wdata   = W2;
        step();
        check_bit("d_l2_write", bus.l2_write, 1'b1);
        check_bit("d_l2_read",  bus.l2_read,  1'b0);
        l2_pulse(PAT_A5);
        step();
        bus.l2_resp = 1'b0;
        bus.d_read  = 1'b0;
        bus.d_write = 1'b0;
        step();

        $display("[TB] I-side grant keeps write data");
        bus.i_read    = 1'b1;
        bus.i_address = 16'h6000;
        step();
        check_bit ("e_l2_read",  bus.l2_read,    1'b1);
        check_addr("e_addr",     bus.l2_address, 16'h6000);
        check_line("e_wdata",    bus.l2_wdata,   W2);
        l2_pulse(PAT_B);
        step();
        bus.l2_resp = 1'b0;
        bus.i_read  = 1'b0;
        step();

        $display("[TB] reset during D service");
        bus.d_read    = 1'b1;
        bus.d_address = 16'h7000;
        step();
        check_bit("f_l2_read_pre", bus.l2_read, 1'b1);
        reset = 1'b1;
        #1;
        check_bit  ("f_l2_read_rst", bus.l2_read,    1'b0);
        check_state("f_state_rst",   dut.state,      IDLE);
        check_addr ("f_addr_rst",    bus.l2_address, 16'h0000);
        bus.d_read = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        l2_pulse(PAT_A5);
        check_bit("f_no_d_resp", bus.d_resp, 1'b0);
        check_bit("f_no_i_resp", bus.i_resp, 1'b0);
        step();
        bus.l2_resp = 1'b0;
        check_state("f_state_after", dut.state,   IDLE);
        check_bit  ("f_l2_read_off", bus.l2_read, 1'b0);

        $display("[TB] spurious l2_resp in IDLE");
        l2_pulse(PAT_B);
        check_bit ("g_i_resp",   bus.i_resp,     1'b0);
        check_bit ("g_d_resp",   bus.d_resp,     1'b0);
        check_bit ("g_l2_read",  bus.l2_read,    1'b0);
        check_bit ("g_l2_write", bus.l2_write,   1'b0);
        check_addr("g_l2_addr",  bus.l2_address, 16'h0000);
        step();
        bus.l2_resp = 1'b0;
        check_state("g_state", dut.state, IDLE);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cache_arbiter.md
CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 Parameter: ADDR_WIDTH, 16, byte address width of all address ports.
REQ-002 Parameter: LINE_WIDTH, 128, cache line width of all data ports.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 i_read  input  1  I-cache line-fill request; held until i_resp.
REQ-006 i_address  input  ADDR_WIDTH  I-cache line address.
REQ-007 i_rdata  output  LINE_WIDTH  fill data to I-cache.
REQ-008 i_resp  output  1  I-cache request complete.
REQ-009 d_read  input  1  D-cache fill request; held until d_resp.
REQ-010 d_write  input  1  D-cache writeback request; held until d_resp.
REQ-011 d_address  input  ADDR_WIDTH  D-cache line address.
REQ-012 d_wdata  input  LINE_WIDTH  D-cache writeback data.
REQ-013 d_rdata  output  LINE_WIDTH  fill data to D-cache.
REQ-014 d_resp  output  1  D-cache request complete.
REQ-015 l2_read, l2_write  output  1 each  request to shared L2.
REQ-016 l2_address  output  ADDR_WIDTH  L2 line address.
REQ-017 l2_wdata  output  LINE_WIDTH  L2 write data.
REQ-018 l2_rdata  input  LINE_WIDTH  L2 read data, valid with l2_resp.
REQ-019 l2_resp  input  1  L2 transaction complete (single-cycle pulse).

Function
REQ-020 FSM states SHALL be IDLE, SERVE_I, SERVE_D, DONE.
REQ-021 IDLE: i_read only -> SERVE_I; d_read or d_write only -> SERVE_D; no request -> IDLE.
REQ-022 IDLE, both requesting: grant the requester not recorded in last_grant (round-robin), then update last_grant to the winner.
REQ-023 On any IDLE->SERVE transition, captured op, address, wdata SHALL be registered; l2_* outputs SHALL be driven only from these registers.
REQ-024 Arbitration latency: request first sampled in cycle N -> l2_read/l2_write asserted from cycle N+1.
REQ-025 d_read and d_write both high: treat as write; captured op = write.
REQ-026 I-side captures op = read, l2_wdata register unchanged.
REQ-027 SERVE_x: hold l2 outputs stable until l2_resp; requester dropping its request mid-service SHALL NOT abort or alter the L2 transaction.
REQ-028 SERVE_x with l2_resp: assert x_resp combinationally that cycle, x_rdata = l2_rdata, deassert l2_read/l2_write next cycle, go to DONE.
REQ-029 i_rdata and d_rdata SHALL equal l2_rdata at all times; only resp is steered.
REQ-030 DONE: exactly one cycle, no grant issued, no resp asserted; then IDLE.
REQ-031 l2_resp in IDLE or DONE SHALL be ignored.
REQ-032 i_resp and d_resp SHALL never be high in the same cycle; l2_read and l2_write never simultaneously high.

Reset
REQ-033 reset SHALL force state=IDLE, last_grant=D (I wins first tie), captured op/address/wdata = 0, immediately and independent of clk.
REQ-034 During reset: l2_read=0, l2_write=0, l2_address=0, l2_wdata=0, i_resp=0, d_resp=0.
REQ-035 Reset mid-SERVE SHALL drop the L2 request; after reset exits, no resp is issued for the aborted transaction.

Structure
REQ-036 Shared package cache_arb_pkg SHALL hold arb_state_t enum, arb_op_t (NONE/READ/WRITE), addr_t and line_t typedefs.
REQ-037 One sub-module, cache_arb_req_reg, SHALL hold the captured op/address/wdata with load enable and async reset.

Verification
REQ-038 i_read=1, i_address=16'h3000; L2 responds 4 cycles later with 128'hA5..A5 -> l2_read from cycle 1, i_resp single pulse with i_rdata=A5..A5, d_resp=0.
REQ-039 i_read and d_read rise together after reset -> I served first; D granted in the cycle after DONE; second tie goes to D.
REQ-040 d_write=1, d_address=16'h4020, d_wdata=128'h1234..; drop d_write mid-service -> l2_write, l2_address, l2_wdata stay constant until l2_resp; d_resp pulses once.
REQ-041 d_read=d_write=1 -> l2_write=1, l2_read=0.
REQ-042 Assert reset during SERVE_D, then pulse l2_resp -> l2_read=0 immediately, no d_resp, state IDLE.
REQ-043 Spurious l2_resp in IDLE with no requests -> no resp outputs, l2 outputs remain 0.
